hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core; sits beside the operand-forwarding mux-select logic. It covers the hazards forwarding cannot resolve:
- load-use dependencies, which need a one-cycle bubble before the MEM-stage load result is forwardable;
- control redirects from EX (JAL, JALR, taken branch);
- data-memory wait states.

It drives the write-enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It keeps a small FSM, a bounded wait counter with a sticky timeout, and saturating performance counters.

## Interface
Parameters:
- TIMEOUT, 16: maximum consecutive memory-freeze cycles before forced release.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- id_rs2_used  in  1  ID instruction reads rs2; 0 for I/U/J-type.
- ex_rd  in  5  EX-stage destination register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_jump_t  in  2  EX jump type: 00 none, 01 JAL, 10 JALR.
- ex_branch_taken  in  1  EX conditional branch resolved taken.
- mem_req  in  1  MEM stage has a load/store in flight.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC register write enable.
- pc_sel  out  1  1 selects the EX redirect target.
- if_id_we  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID load bubble.
- id_ex_we  out  1  ID/EX write enable.
- id_ex_flush  out  1  ID/EX load bubble.
- ex_mem_we  out  1  EX/MEM write enable.
- mem_wb_bubble  out  1  MEM/WB load bubble.
- busy  out  1  FSM in MEM_WAIT.
- mem_timeout  out  1  sticky: a memory wait exceeded TIMEOUT.
- stall_cnt  out  CNT_W  cycles with pc_we=0, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.

## Operation
Derived terms:
- redirect = (ex_jump_t==01 | ex_jump_t==10 | ex_branch_taken).
- load_use = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_rs2_used & ex_rd==id_rs2)).
- mem_wait = mem_req & ~mem_ready & ~mem_timeout.
- freeze = mem_wait & (wcnt < TIMEOUT).
- expire = mem_wait & (wcnt == TIMEOUT).

Per-cycle decode is combinational in the current inputs plus wcnt and mem_timeout. It is strictly prioritised:
1. freeze: all write-enables 0; mem_wb_bubble=1; no flushes; pc_sel=0.
2. else redirect: pc_we=1, pc_sel=1, if_id_we=1, if_id_flush=1, id_ex_we=1, id_ex_flush=1, ex_mem_we=1.
3. else load_use: pc_we=0, if_id_we=0, id_ex_we=1, id_ex_flush=1, ex_mem_we=1.
4. else: all write-enables 1, all flush/bubble 0, pc_sel=0.
- expire behaves as not-freeze: the decode falls through to rows 2-4.
- Row 3 is never asserted together with row 2. A redirect wins, because the dependent ID instruction is flushed anyway.

FSM (state register, 1 bit):
- RUN→MEM_WAIT on freeze.
- MEM_WAIT stays on freeze.
- MEM_WAIT→RUN when freeze=0 (mem_ready, mem_req drop, or expire).
- busy = (state==MEM_WAIT).

wcnt (internal, clog2(TIMEOUT+1) bits):
- +1 on each freeze cycle; cleared on any non-freeze cycle.
- Freezes per wait are therefore at most TIMEOUT.

mem_timeout:
- set on the edge after an expire cycle; held until rst.
- While set, mem_wait=0: memory waits are ignored and the pipeline never freezes.

Counters (saturate at all-ones, no wrap):
- stall_cnt +1 every cycle pc_we=0.
- flush_cnt +1 every row-2 cycle.

## Timing
- Reset (rst=1 at an edge): state=RUN, wcnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- Outputs during and immediately after reset follow row 4, given inactive inputs.
- Control outputs are combinational, zero latency, same cycle as the inputs. They must settle before the pipeline register edge.
- Registered state (state, wcnt, mem_timeout, counters) updates on the rising edge following the qualifying cycle.
- Load-use is exactly one bubble: the next cycle the load sits in MEM, ex_mem_read from the bubble is 0, and the forwarding path takes over.
- Redirect during a wait: EX is frozen, so redirect stays asserted. The flush executes in the cycle mem_ready=1.
- Memory wait: mem_ready asserted in the same cycle as mem_req gives zero freeze cycles.
- rst mid-wait: returns to RUN next edge; counters and the sticky flag clear.

## Test plan
- Load-use hazard:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs1=5, one cycle.
  - Response: pc_we=0, if_id_we=0, id_ex_flush=1; stall_cnt 0→1.
  - Repeat with id_rs2=5, id_rs2_used=0: no stall.
  - Repeat with ex_rd=0: no stall.
- JALR redirect coincident with load-use:
  - Stimulus: ex_jump_t=10 plus load_use conditions.
  - Response: pc_sel=1, if_id_flush=1, id_ex_flush=1, pc_we=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait of 3 cycles:
  - Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then 1.
  - Response: 3 cycles with every write-enable 0 and mem_wb_bubble=1; busy=1 from the 2nd through 4th cycle; stall_cnt=3; RUN after the ready edge.
- Timeout, TIMEOUT=4:
  - Stimulus: mem_req=1, mem_ready=0 held.
  - Response: 4 freeze cycles; the 5th cycle advances with pc_we=1; mem_timeout=1 after that edge and stays 1; no further freezes.
- Redirect during wait:
  - Stimulus: ex_branch_taken=1 throughout a 2-cycle wait.
  - Response: no flush while frozen; flush and pc_sel=1 in the mem_ready cycle; flush_cnt=1.
- Reset mid-wait and counter saturation:
  - Stimulus: rst pulse during MEM_WAIT.
  - Response: next cycle busy=0, counters 0.
  - Stimulus: CNT_W=4 with 20 load-use stalls.
  - Response: stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// Handles load-use bubbles, EX redirects and data-memory wait states,
// with a bounded wait counter, a sticky timeout flag and saturating
// performance counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [1:0]       ex_jump_t,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic             busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WCNT_W-1:0] wcnt;

  logic redirect;
  logic load_use;
  logic mem_wait;
  logic freeze;
  logic expire;
  logic do_redirect;

  // Hazard terms derived from the current inputs and the wait bookkeeping.
  always_comb begin
    redirect    = (ex_jump_t == 2'b01) || (ex_jump_t == 2'b10) || ex_branch_taken;
    load_use    = ex_mem_read && (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs1) || (id_rs2_used && (ex_rd == id_rs2)));
    mem_wait    = mem_req && !mem_ready && !mem_timeout;
    freeze      = mem_wait && (wcnt < WCNT_LIMIT);
    expire      = mem_wait && (wcnt == WCNT_LIMIT);
    do_redirect = redirect && !freeze;
  end

  // Prioritised control decode: freeze, then redirect, then load-use bubble.
  always_comb begin
    pc_we         = 1'b1;
    pc_sel        = 1'b0;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;
    state_next    = state;
    if (freeze) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (redirect) begin
      pc_sel      = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
    case (state)
      RUN:      if (freeze)  state_next = MEM_WAIT;
      MEM_WAIT: if (!freeze) state_next = RUN;
      default:  state_next = RUN;
    endcase
    busy = (state == MEM_WAIT);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Consecutive-freeze counter and sticky timeout flag; an expired wait
  // latches the flag so later waits are ignored until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wcnt <= freeze ? (wcnt + WCNT_W'(1)) : '0;
      if (expire) mem_timeout <= 1'b1;
    end
  end

  // Saturating stall and redirect counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (do_redirect && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl
// (TIMEOUT=4, CNT_W=4 so timeout and saturation are reachable quickly).
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // Control vectors: {pc_we, pc_sel, if_id_we, if_id_flush,
  //                   id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble}
  localparam logic [7:0] ROW_FRZ = 8'b0000_0001;
  localparam logic [7:0] ROW_RED = 8'b1111_1110;
  localparam logic [7:0] ROW_LU  = 8'b0000_1110;
  localparam logic [7:0] ROW_RUN = 8'b1010_1010;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_rs2_used, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic [1:0]       ex_jump_t;
  logic             pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic             ex_mem_we, mem_wb_bubble, busy, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string       tag;
    logic [17:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_jump_t(ex_jump_t),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
    .mem_wb_bubble(mem_wb_bubble), .busy(busy), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic applyStimulus(input string tag, input logic r,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic rs2u, input logic [4:0] rd,
                               input logic mr, input logic [1:0] jt,
                               input logic bt, input logic req, input logic rdy,
                               input logic [7:0] ctrl, input logic b,
                               input logic t, input logic [3:0] s,
                               input logic [3:0] f);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_rs2_used = rs2u; ex_rd = rd;
    ex_mem_read = mr; ex_jump_t = jt; ex_branch_taken = bt;
    mem_req = req; mem_ready = rdy;
    e.tag = tag;
    e.vec = {ctrl, b, t, s, f};
    exp_q.push_back(e);
  endtask

  // Sample on the falling edge and compare against the oldest expectation.
  task automatic checkOutput();
    exp_t        e;
    logic [17:0] obs;
    @(negedge clk);
    e   = exp_q.pop_front();
    obs = {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
           ex_mem_we, mem_wb_bubble, busy, mem_timeout, stall_cnt, flush_cnt};
    total++;
    assert (obs === e.vec) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
    end
  endtask

  task automatic idle(input string tag, input logic r, input logic [7:0] ctrl,
                      input logic b, input logic t, input logic [3:0] s,
                      input logic [3:0] f);
    applyStimulus(tag, r, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                  ctrl, b, t, s, f);
    checkOutput();
  endtask

  task automatic mem(input string tag, input logic r, input logic bt,
                     input logic rdy, input logic [7:0] ctrl, input logic b,
                     input logic t, input logic [3:0] s, input logic [3:0] f);
    applyStimulus(tag, r, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, bt, 1'b1, rdy,
                  ctrl, b, t, s, f);
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rs2_used = 1'b0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_jump_t = 2'b00; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);

    idle("reset", 1'b1, ROW_RUN, 1'b0, 1'b0, 4'd0, 4'd0);
    idle("post_reset", 1'b0, ROW_RUN, 1'b0, 1'b0, 4'd0, 4'd0);

    // Load-use through rs1, then the no-stall variants.
    applyStimulus("lu_rs1", 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0,
                  ROW_LU, 1'b0, 1'b0, 4'd0, 4'd0);
    checkOutput();
    idle("lu_after", 1'b0, ROW_RUN, 1'b0, 1'b0, 4'd1, 4'd0);
    applyStimulus("lu_rs2_unused", 1'b0, 5'd0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0,
                  ROW_RUN, 1'b0, 1'b0, 4'd1, 4'd0);
    checkOutput();
    applyStimulus("lu_rd_zero", 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0,
                  ROW_RUN, 1'b0, 1'b0, 4'd1, 4'd0);
    checkOutput();
    applyStimulus("lu_rs2_used", 1'b0, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0,
                  ROW_LU, 1'b0, 1'b0, 4'd1, 4'd0);
    checkOutput();

    // JALR coincident with load-use: redirect wins.
    applyStimulus("jalr_lu", 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0,
                  ROW_RED, 1'b0, 1'b0, 4'd2, 4'd0);
    checkOutput();
    applyStimulus("jt_11_none", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0,
                  ROW_RUN, 1'b0, 1'b0, 4'd2, 4'd1);
    checkOutput();
    applyStimulus("jal", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0,
                  ROW_RED, 1'b0, 1'b0, 4'd2, 4'd1);
    checkOutput();

    // Three-cycle memory wait.
    mem("wait3_c1", 1'b0, 1'b0, 1'b0, ROW_FRZ, 1'b0, 1'b0, 4'd2, 4'd2);
    mem("wait3_c2", 1'b0, 1'b0, 1'b0, ROW_FRZ, 1'b1, 1'b0, 4'd3, 4'd2);
    mem("wait3_c3", 1'b0, 1'b0, 1'b0, ROW_FRZ, 1'b1, 1'b0, 4'd4, 4'd2);
    mem("wait3_ready", 1'b0, 1'b0, 1'b1, ROW_RUN, 1'b1, 1'b0, 4'd5, 4'd2);
    idle("wait3_run", 1'b0, ROW_RUN, 1'b0, 1'b0, 4'd5, 4'd2);
    idle("rst_a", 1'b1, ROW_RUN, 1'b0, 1'b0, 4'd5, 4'd2);
    idle("rst_a_done", 1'b0, ROW_RUN, 1'b0, 1'b0, 4'd0, 4'd0);

    // Timeout: four freezes, the fifth cycle advances, flag sticks.
    mem("tmo_c1", 1'b0, 1'b0, 1'b0, ROW_FRZ, 1'b0, 1'b0, 4'd0, 4'd0);
    mem("tmo_c2", 1'b0, 1'b0, 1'b0, ROW_FRZ, 1'b1, 1'b0, 4'd1, 4'd0);
    mem("tmo_c3", 1'b0, 1'b0, 1'b0, ROW_FRZ, 1'b1, 1'b0, 4'd2, 4'd0);
    mem("tmo_c4", 1'b0, 1'b0, 1'b0, ROW_FRZ, 1'b1, 1'b0, 4'd3, 4'd0);
    mem("tmo_expire", 1'b0, 1'b0, 1'b0, ROW_RUN, 1'b1, 1'b0, 4'd4, 4'd0);
    mem("tmo_sticky1", 1'b0, 1'b0, 1'b0, ROW_RUN, 1'b0, 1'b1, 4'd4, 4'd0);
    mem("tmo_sticky2", 1'b0, 1'b0, 1'b0, ROW_RUN, 1'b0, 1'b1, 4'd4, 4'd0);
    idle("rst_b", 1'b1, ROW_RUN, 1'b0, 1'b1, 4'd4, 4'd0);
    idle("rst_b_done", 1'b0, ROW_RUN, 1'b0, 1'b0, 4'd0, 4'd0);

    // Taken branch held through a two-cycle wait.
    mem("redwait_c1", 1'b0, 1'b1, 1'b0, ROW_FRZ, 1'b0, 1'b0, 4'd0, 4'd0);
    mem("redwait_c2", 1'b0, 1'b1, 1'b0, ROW_FRZ, 1'b1, 1'b0, 4'd1, 4'd0);
    mem("redwait_ready", 1'b0, 1'b1, 1'b1, ROW_RED, 1'b1, 1'b0, 4'd2, 4'd0);
    idle("redwait_done", 1'b0, ROW_RUN, 1'b0, 1'b0, 4'd2, 4'd1);

    // Ready in the same cycle as the request: no freeze.
    mem("ready_same", 1'b0, 1'b0, 1'b1, ROW_RUN, 1'b0, 1'b0, 4'd2, 4'd1);

    // Reset in the middle of a wait.
    mem("rstwait_c1", 1'b0, 1'b0, 1'b0, ROW_FRZ, 1'b0, 1'b0, 4'd2, 4'd1);
    mem("rstwait_c2", 1'b0, 1'b0, 1'b0, ROW_FRZ, 1'b1, 1'b0, 4'd3, 4'd1);
    mem("rstwait_rst", 1'b1, 1'b0, 1'b0, ROW_FRZ, 1'b1, 1'b0, 4'd4, 4'd1);
    idle("rstwait_done", 1'b0, ROW_RUN, 1'b0, 1'b0, 4'd0, 4'd0);

    // Twenty load-use stalls saturate the 4-bit stall counter at 15.
    for (int i = 0; i < 20; i++) begin
      applyStimulus("sat_lu", 1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0,
                    ROW_LU, 1'b0, 1'b0, (i > 15) ? 4'd15 : 4'(i), 4'd0);
      checkOutput();
    end
    idle("sat_hold", 1'b0, ROW_RUN, 1'b0, 1'b0, 4'd15, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
